// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between an ICache fill
// port, a DCache fill port and a DCache writeback port.
// Optional feature: define MEM_ARBITER_RR_EN to arbitrate the two read
// ports round-robin (writeback stays highest priority). Default build is
// fixed priority dWr > dRd > iRd.
module mem_arbiter #(
    parameter int unsigned ARCH_BITS        = 32,
    parameter int unsigned MEMORY_LINE_BITS = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    // ICache fill port
    input  logic [ARCH_BITS-1:0]        iRdAddr,
    input  logic                        iRdReq,
    output logic [MEMORY_LINE_BITS-1:0] iRdLine,
    output logic                        iRdValid,
    // DCache fill port
    input  logic [ARCH_BITS-1:0]        dRdAddr,
    input  logic                        dRdReq,
    output logic [MEMORY_LINE_BITS-1:0] dRdLine,
    output logic                        dRdValid,
    // DCache writeback port
    input  logic [ARCH_BITS-1:0]        dWrAddr,
    input  logic                        dWrReq,
    input  logic [MEMORY_LINE_BITS-1:0] dWrLine,
    output logic                        dWrDone,
    // memory port
    output logic [ARCH_BITS-1:0]        memAddr,
    output logic                        memReq,
    output logic                        memWe,
    output logic [MEMORY_LINE_BITS-1:0] memWLine,
    input  logic [MEMORY_LINE_BITS-1:0] memRLine,
    input  logic                        memAck,
    // status
    output logic [1:0]                  grant,
    output logic                        busy
);

    localparam int unsigned OFFSET_BITS = 4;
    localparam logic [ARCH_BITS-1:0] LINE_MASK = ~ARCH_BITS'((1 << OFFSET_BITS) - 1);

    localparam logic [1:0] GRANT_NONE = 2'd0;
    localparam logic [1:0] GRANT_IRD  = 2'd1;
    localparam logic [1:0] GRANT_DRD  = 2'd2;
    localparam logic [1:0] GRANT_DWR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [ARCH_BITS-1:0]        r_mem_addr,  w_mem_addr_nxt;
    logic                        r_mem_req,   w_mem_req_nxt;
    logic                        r_mem_we,    w_mem_we_nxt;
    logic [MEMORY_LINE_BITS-1:0] r_mem_wline, w_mem_wline_nxt;
    logic [MEMORY_LINE_BITS-1:0] r_i_line,    w_i_line_nxt;
    logic [MEMORY_LINE_BITS-1:0] r_d_line,    w_d_line_nxt;
    logic                        r_i_valid,   w_i_valid_nxt;
    logic                        r_d_valid,   w_d_valid_nxt;
    logic                        r_wr_done,   w_wr_done_nxt;
    logic [1:0]                  r_grant,     w_grant_nxt;
    logic                        r_busy,      w_busy_nxt;

    logic [1:0]                  w_win;
    logic [ARCH_BITS-1:0]        w_sel_addr;
    logic [MEMORY_LINE_BITS-1:0] w_sel_wline;

`ifdef MEM_ARBITER_RR_EN
    // 1 = ICache was the last read port served, so DCache wins the next conflict
    logic                        r_rr_last_i, w_rr_last_i_nxt;
`endif

    // Pick the winning requester for this IDLE cycle
    always_comb begin
        w_win = GRANT_NONE;
        if (dWrReq) begin
            w_win = GRANT_DWR;
`ifdef MEM_ARBITER_RR_EN
        end else if (dRdReq && iRdReq) begin
            w_win = r_rr_last_i ? GRANT_DRD : GRANT_IRD;
`endif
        end else if (dRdReq) begin
            w_win = GRANT_DRD;
        end else if (iRdReq) begin
            w_win = GRANT_IRD;
        end
    end

    // Route the winner's address and data; reads carry no write data
    always_comb begin
        w_sel_addr  = iRdAddr;
        w_sel_wline = '0;
        case (w_win)
            GRANT_DWR: begin
                w_sel_addr  = dWrAddr;
                w_sel_wline = dWrLine;
            end
            GRANT_DRD: w_sel_addr = dRdAddr;
            default:   w_sel_addr = iRdAddr;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_wline_nxt = r_mem_wline;
        w_i_line_nxt    = r_i_line;
        w_d_line_nxt    = r_d_line;
        w_i_valid_nxt   = 1'b0;
        w_d_valid_nxt   = 1'b0;
        w_wr_done_nxt   = 1'b0;
        w_grant_nxt     = r_grant;
        w_busy_nxt      = r_busy;
`ifdef MEM_ARBITER_RR_EN
        w_rr_last_i_nxt = r_rr_last_i;
`endif

        case (r_state)
            ST_IDLE: begin
                if (w_win != GRANT_NONE) begin
                    w_state_nxt     = ST_ISSUE;
                    w_mem_addr_nxt  = w_sel_addr & LINE_MASK;
                    w_mem_we_nxt    = (w_win == GRANT_DWR);
                    w_mem_wline_nxt = w_sel_wline;
                    w_mem_req_nxt   = 1'b1;
                    w_grant_nxt     = w_win;
                    w_busy_nxt      = 1'b1;
`ifdef MEM_ARBITER_RR_EN
                    if (w_win != GRANT_DWR) begin
                        w_rr_last_i_nxt = (w_win == GRANT_IRD);
                    end
`endif
                end
            end
            ST_ISSUE: begin
                // no timeout: memory may take arbitrarily long to acknowledge
                if (memAck) begin
                    w_state_nxt   = ST_RESP;
                    w_mem_req_nxt = 1'b0;
                    case (r_grant)
                        GRANT_IRD: begin
                            w_i_line_nxt  = memRLine;
                            w_i_valid_nxt = 1'b1;
                        end
                        GRANT_DRD: begin
                            w_d_line_nxt  = memRLine;
                            w_d_valid_nxt = 1'b1;
                        end
                        default: w_wr_done_nxt = 1'b1;
                    endcase
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = GRANT_NONE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_mem_req_nxt = 1'b0;
                w_grant_nxt   = GRANT_NONE;
                w_busy_nxt    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mem_addr  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wline <= '0;
            r_i_line    <= '0;
            r_d_line    <= '0;
            r_i_valid   <= 1'b0;
            r_d_valid   <= 1'b0;
            r_wr_done   <= 1'b0;
            r_grant     <= GRANT_NONE;
            r_busy      <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            r_rr_last_i <= 1'b1;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_wline <= w_mem_wline_nxt;
            r_i_line    <= w_i_line_nxt;
            r_d_line    <= w_d_line_nxt;
            r_i_valid   <= w_i_valid_nxt;
            r_d_valid   <= w_d_valid_nxt;
            r_wr_done   <= w_wr_done_nxt;
            r_grant     <= w_grant_nxt;
            r_busy      <= w_busy_nxt;
`ifdef MEM_ARBITER_RR_EN
            r_rr_last_i <= w_rr_last_i_nxt;
`endif
        end
    end

    assign memAddr  = r_mem_addr;
    assign memReq   = r_mem_req;
    assign memWe    = r_mem_we;
    assign memWLine = r_mem_wline;
    assign iRdLine  = r_i_line;
    assign dRdLine  = r_d_line;
    assign iRdValid = r_i_valid;
    assign dRdValid = r_d_valid;
    assign dWrDone  = r_wr_done;
    assign grant    = r_grant;
    assign busy     = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard for mem_arbiter.
// Expected memory transactions and response pulses are queued by the
// stimulus; a monitor pops and compares them as the DUT presents them.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 128;
    localparam logic [1:0] K_IRD = 2'd1;
    localparam logic [1:0] K_DRD = 2'd2;
    localparam logic [1:0] K_DWR = 2'd3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [LW-1:0] wline;
    } mem_exp_t;

    typedef struct packed {
        logic [1:0]    kind;
        logic [LW-1:0] line;
    } rsp_exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] iRdAddr, dRdAddr, dWrAddr, memAddr;
    logic          iRdReq, dRdReq, dWrReq;
    logic [LW-1:0] dWrLine, iRdLine, dRdLine, memWLine, memRLine;
    logic          iRdValid, dRdValid, dWrDone;
    logic          memReq, memWe, memAck;
    logic [1:0]    grant;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    mem_exp_t exp_mem[$];
    rsp_exp_t exp_rsp[$];
    logic [LW-1:0] mem_model [logic [AW-1:0]];

    bit            mem_en    = 1'b1;
    int            ack_delay = 3;
    int            mcnt      = 0;
    logic          spur_ack  = 1'b0;
    logic          m_ack     = 1'b0;
    logic [LW-1:0] m_rline   = '0;

    assign memAck   = m_ack | spur_ack;
    assign memRLine = m_rline;

    always #5 clk = ~clk;

    mem_arbiter #(.ARCH_BITS(AW), .MEMORY_LINE_BITS(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .iRdAddr  (iRdAddr),
        .iRdReq   (iRdReq),
        .iRdLine  (iRdLine),
        .iRdValid (iRdValid),
        .dRdAddr  (dRdAddr),
        .dRdReq   (dRdReq),
        .dRdLine  (dRdLine),
        .dRdValid (dRdValid),
        .dWrAddr  (dWrAddr),
        .dWrReq   (dWrReq),
        .dWrLine  (dWrLine),
        .dWrDone  (dWrDone),
        .memAddr  (memAddr),
        .memReq   (memReq),
        .memWe    (memWe),
        .memWLine (memWLine),
        .memRLine (memRLine),
        .memAck   (memAck),
        .grant    (grant),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Memory model: acks ack_delay cycles after memReq rises, performs the access
    initial begin
        mem_model[32'h1000] = {16{8'hA5}};
        mem_model[32'h3000] = {8{16'h1111}};
        mem_model[32'h4000] = {8{16'h4444}};
        mem_model[32'h5000] = {8{16'h5555}};
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            if (memReq === 1'b1 && mem_en && rst === 1'b0) begin
                mcnt++;
                if (mcnt == ack_delay + 1) begin
                    m_ack = 1'b1;
                    if (memWe) mem_model[memAddr] = memWLine;
                    else m_rline = mem_model.exists(memAddr) ? mem_model[memAddr] : '0;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // Monitor: compares memory requests and response pulses against the queues
    mem_exp_t cur_mem;
    rsp_exp_t cur_rsp;
    logic     prev_req = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (memReq === 1'b1 && prev_req !== 1'b1) begin
                    if (exp_mem.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL mem_unexpected_req actual=%0h required=none", memAddr);
                        cur_mem = '{addr: memAddr, we: memWe, wline: memWLine};
                    end else begin
                        cur_mem = exp_mem.pop_front();
                        check("mem_addr", memAddr, cur_mem.addr);
                        check("mem_we", memWe, cur_mem.we);
                        if (cur_mem.we) check("mem_wline", memWLine, cur_mem.wline);
                    end
                end else if (memReq === 1'b1) begin
                    check("mem_addr_stable", memAddr, cur_mem.addr);
                    check("mem_we_stable", memWe, cur_mem.we);
                    if (cur_mem.we) check("mem_wline_stable", memWLine, cur_mem.wline);
                end
                if (iRdValid === 1'b1 || dRdValid === 1'b1 || dWrDone === 1'b1) begin
                    check("rsp_one_pulse", 128'(int'(iRdValid === 1'b1) + int'(dRdValid === 1'b1)
                          + int'(dWrDone === 1'b1)), 128'd1);
                    if (exp_rsp.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL rsp_unexpected actual=%b%b%b required=none", iRdValid, dRdValid, dWrDone);
                    end else begin
                        cur_rsp = exp_rsp.pop_front();
                        check("rsp_kind", (dWrDone === 1'b1) ? K_DWR : (dRdValid === 1'b1) ? K_DRD : K_IRD,
                              cur_rsp.kind);
                        check("rsp_grant", grant, cur_rsp.kind);
                        if (cur_rsp.kind == K_IRD) check("iRdLine", iRdLine, cur_rsp.line);
                        if (cur_rsp.kind == K_DRD) check("dRdLine", dRdLine, cur_rsp.line);
                    end
                end
            end
            prev_req = memReq;
        end
    end

    // Wait for n response pulses within a cycle budget, optionally dropping served requests
    task automatic wait_pulses(input int n, input int budget, input bit drop, output int cycles);
        int seen = 0;
        cycles = 0;
        while (seen < n && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (iRdValid === 1'b1 || dRdValid === 1'b1 || dWrDone === 1'b1) begin
                seen++;
                if (drop) begin
                    if (iRdValid === 1'b1) iRdReq = 1'b0;
                    if (dRdValid === 1'b1) dRdReq = 1'b0;
                    if (dWrDone === 1'b1)  dWrReq = 1'b0;
                end
            end
        end
        if (seen < n) begin
            checks++; failures++;
            $display("FAIL pulse_timeout actual=%0d required=%0d", seen, n);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_grant"}, grant, 2'd0);
        check({name, "_memReq"}, memReq, 1'b0);
        check({name, "_pulses"}, {iRdValid, dRdValid, dWrDone}, 3'b000);
    endtask

    int cyc;

    // Directed stimulus
    initial begin
        rst = 1'b1;
        iRdReq = 1'b0; dRdReq = 1'b0; dWrReq = 1'b0;
        iRdAddr = '0; dRdAddr = '0; dWrAddr = '0; dWrLine = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_memWe", memWe, 1'b0);
        check("reset_memAddr", memAddr, '0);
        check("reset_memWLine", memWLine, '0);
        check("reset_iRdLine", iRdLine, '0);
        check("reset_dRdLine", dRdLine, '0);
        rst = 1'b0;

        // spurious memAck with nothing pending
        spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle("spurious_idle");
        end

        // single ICache fill, ack 3 cycles after memReq rises
        ack_delay = 3;
        exp_mem.push_back('{addr: 32'h1000, we: 1'b0, wline: '0});
        exp_rsp.push_back('{kind: K_IRD, line: {16{8'hA5}}});
        iRdAddr = 32'h1004; iRdReq = 1'b1;
        @(negedge clk);
        check("t1_memReq", memReq, 1'b1);
        check("t1_grant", grant, K_IRD);
        check("t1_busy", busy, 1'b1);
        wait_pulses(1, 20, 1'b1, cyc);
        check("t1_latency", cyc, 4);
        @(negedge clk);
        check_idle("t1_after");
        check("t1_iRdLine_held", iRdLine, {16{8'hA5}});

        // writeback: aligned address, stable data, single done pulse
        ack_delay = 4;
        exp_mem.push_back('{addr: 32'h8000, we: 1'b1, wline: 128'h1234});
        exp_rsp.push_back('{kind: K_DWR, line: '0});
        dWrAddr = 32'h800C; dWrLine = 128'h1234; dWrReq = 1'b1;
        wait_pulses(1, 20, 1'b1, cyc);
        check("t6_latency", cyc, 6);
        @(negedge clk);
        check_idle("t6_after");
        check("t6_mem_written", mem_model[32'h8000], 128'h1234);
        check("t6_iRdLine_held", iRdLine, {16{8'hA5}});
        check("t6_dRdLine_held", dRdLine, '0);

        // three simultaneous requests: write first, then same-line fill sees new data
        ack_delay = 1;
        exp_mem.push_back('{addr: 32'h2000, we: 1'b1, wline: {4{32'hCAFEF00D}}});
        exp_mem.push_back('{addr: 32'h2000, we: 1'b0, wline: '0});
        exp_mem.push_back('{addr: 32'h3000, we: 1'b0, wline: '0});
        exp_rsp.push_back('{kind: K_DWR, line: '0});
        exp_rsp.push_back('{kind: K_DRD, line: {4{32'hCAFEF00D}}});
        exp_rsp.push_back('{kind: K_IRD, line: {8{16'h1111}}});
        dWrAddr = 32'h2008; dWrLine = {4{32'hCAFEF00D}}; dRdAddr = 32'h2004; iRdAddr = 32'h3000;
        dWrReq = 1'b1; dRdReq = 1'b1; iRdReq = 1'b1;
        wait_pulses(3, 60, 1'b1, cyc);
        repeat (4) @(negedge clk);
        check_idle("t2_after");
        check("t2_rsp_drained", exp_rsp.size(), 0);

        // both reads held continuously for four grants, back to back
        ack_delay = 0;
        dRdAddr = 32'h4000; iRdAddr = 32'h5000;
`ifdef MEM_ARBITER_RR_EN
        for (int i = 0; i < 2; i++) begin
            exp_mem.push_back('{addr: 32'h4000, we: 1'b0, wline: '0});
            exp_mem.push_back('{addr: 32'h5000, we: 1'b0, wline: '0});
            exp_rsp.push_back('{kind: K_DRD, line: {8{16'h4444}}});
            exp_rsp.push_back('{kind: K_IRD, line: {8{16'h5555}}});
        end
`else
        for (int i = 0; i < 4; i++) begin
            exp_mem.push_back('{addr: 32'h4000, we: 1'b0, wline: '0});
            exp_rsp.push_back('{kind: K_DRD, line: {8{16'h4444}}});
        end
`endif
        dRdReq = 1'b1; iRdReq = 1'b1;
        wait_pulses(4, 60, 1'b0, cyc);
        dRdReq = 1'b0; iRdReq = 1'b0;
        check("t3_spacing", cyc, 11);
        repeat (3) @(negedge clk);
        check_idle("t3_after");
        check("t3_rsp_drained", exp_rsp.size(), 0);

        // reset two cycles into ISSUE drops the transaction
        mem_en = 1'b0;
        exp_mem.push_back('{addr: 32'h6000, we: 1'b0, wline: '0});
        dRdAddr = 32'h6000; dRdReq = 1'b1;
        @(negedge clk);
        check("t4_memReq", memReq, 1'b1);
        @(negedge clk);
        rst = 1'b1; dRdReq = 1'b0;
        @(negedge clk);
        check_idle("t4_reset");
        rst = 1'b0;
        spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle("t4_late_ack");
        end
        mem_en = 1'b1;

        repeat (2) @(negedge clk);
        check("final_mem_drained", exp_mem.size(), 0);
        check("final_rsp_drained", exp_rsp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the parameter ARCH_BITS, default 32: address width.
REQ-002 The block SHALL have the parameter MEMORY_LINE_BITS, default 128: line width in bits.
REQ-003 The block SHALL have the port clk  in  1: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have the port rst  in  1: synchronous, active-high reset.
REQ-005 The block SHALL have the port iRdAddr  in  ARCH_BITS: ICache fill address.
REQ-006 The block SHALL have the port iRdReq  in  1: ICache fill request, a level held until iRdValid.
REQ-007 The block SHALL have the port iRdLine  out  MEMORY_LINE_BITS: ICache fill data.
REQ-008 The block SHALL have the port iRdValid  out  1: one-cycle pulse marking iRdLine valid.
REQ-009 The block SHALL have the port dRdAddr  in  ARCH_BITS: DCache fill address.
REQ-010 The block SHALL have the port dRdReq  in  1: DCache fill request, a level held until dRdValid.
REQ-011 The block SHALL have the port dRdLine  out  MEMORY_LINE_BITS: DCache fill data.
REQ-012 The block SHALL have the port dRdValid  out  1: one-cycle pulse marking dRdLine valid.
REQ-013 The block SHALL have the port dWrAddr  in  ARCH_BITS: DCache writeback address.
REQ-014 The block SHALL have the port dWrReq  in  1: writeback request, a level held until dWrDone.
REQ-015 The block SHALL have the port dWrLine  in  MEMORY_LINE_BITS: writeback data.
REQ-016 The block SHALL have the port dWrDone  out  1: one-cycle pulse marking writeback complete.
REQ-017 The block SHALL have the port memAddr  out  ARCH_BITS: line-aligned address to memory.
REQ-018 The block SHALL have the port memReq  out  1: memory request, held until memAck.
REQ-019 The block SHALL have the port memWe  out  1: 1 = write, 0 = read; valid while memReq=1.
REQ-020 The block SHALL have the port memWLine  out  MEMORY_LINE_BITS: write data to memory.
REQ-021 The block SHALL have the port memRLine  in  MEMORY_LINE_BITS: read data, valid when memAck=1.
REQ-022 The block SHALL have the port memAck  in  1: one-cycle completion pulse from memory.
REQ-023 The block SHALL have the port grant  out  2: current owner; 0 = none, 1 = ICache read, 2 = DCache read, 3 = DCache write.
REQ-024 The block SHALL have the port busy  out  1: high whenever the FSM is not IDLE.

Function
REQ-025 The FSM SHALL have the states IDLE, ISSUE and RESP.
REQ-026 IDLE: when any request is high, the block SHALL latch the winner's address, with bits [3:0] cleared, plus the winner's data and type, and go to ISSUE on the next edge; with no request it SHALL stay in IDLE.
REQ-027 Default arbitration SHALL be fixed priority: dWrReq > dRdReq > iRdReq.
REQ-028 Writeback SHALL always win over reads, so a pending dirty-line write SHALL precede a same-line DCache fill.
REQ-029 ISSUE: memReq SHALL be 1 with memAddr, memWe and memWLine held stable; these SHALL be registered outputs that are constant for the whole ISSUE interval.
REQ-030 On memAck=1 in ISSUE, the block SHALL capture memRLine for reads and go to RESP.
REQ-031 ISSUE SHALL have no timeout; the block SHALL wait for memAck indefinitely.
REQ-032 RESP: the block SHALL pulse exactly one of iRdValid, dRdValid or dWrDone for one cycle, with the captured line on iRdLine or dRdLine, then return to IDLE.
REQ-033 iRdLine and dRdLine SHALL hold their last value outside RESP.
REQ-034 Latency: with a request sampled in IDLE at cycle t, memReq SHALL first be high at t+1; memAck at cycle t+1+k SHALL give the response pulse at t+2+k and IDLE at t+3+k.
REQ-035 The minimum back-to-back spacing between grants SHALL be 3 cycles.
REQ-036 memAck while not in ISSUE SHALL be ignored, with no state change.
REQ-037 Requests SHALL be ignored outside IDLE.
REQ-038 A requester SHALL drop its request in the cycle after its response pulse.
REQ-039 A request still high in IDLE after its response SHALL be treated as a new request.
REQ-040 Requests arriving while busy SHALL be served in priority order once the FSM returns to IDLE, and none SHALL be lost while held.
REQ-041 grant SHALL reflect the latched owner in ISSUE and RESP, and SHALL be 0 in IDLE.

Reset
REQ-042 While rst=1 the FSM SHALL be forced to IDLE on the next edge, regardless of state, including mid-ISSUE; an in-flight transaction SHALL be dropped without a response pulse.
REQ-043 Reset values SHALL be: memReq=0, memWe=0, memAddr=0, memWLine=0, iRdValid=0, dRdValid=0, dWrDone=0, iRdLine=0, dRdLine=0, grant=0, busy=0, round-robin pointer = ICache.

Configuration
REQ-044 With macro MEM_ARBITER_RR_EN defined, the two read requesters SHALL be arbitrated round-robin: after serving one read port, the other read port SHALL win the next simultaneous read conflict; writes SHALL remain highest priority.
REQ-045 Without MEM_ARBITER_RR_EN, fixed priority per REQ-027 SHALL apply, no pointer register SHALL exist, and ICache starvation under continuous DCache traffic is permitted.

Verification
REQ-046 Bench SHALL cover: iRdReq=1 with iRdAddr=0x1004 at t=0 and memAck 3 cycles after memReq rises with memRLine=0xA5..A5 -> memAddr=0x1000, memWe=0, iRdValid pulses once with iRdLine=0xA5..A5, grant=1 then 0.
REQ-047 Bench SHALL cover: dWrReq, dRdReq and iRdReq raised in the same cycle, each held until serviced -> service order dWr (memWe=1), dRd, iRd; exactly 3 response pulses.
REQ-048 Bench SHALL cover: dRdReq and iRdReq held continuously for 4 grants -> without the macro 4 dRd grants and 0 iRd grants; with MEM_ARBITER_RR_EN alternating dRd, iRd, dRd, iRd.
REQ-049 Bench SHALL cover: rst asserted 2 cycles into ISSUE -> memReq=0 and grant=0 the next cycle, no response pulse, and a later memAck is ignored.
REQ-050 Bench SHALL cover: spurious memAck in IDLE with no requests -> no state change and all pulses stay 0.
REQ-051 Bench SHALL cover: dWrReq with dWrAddr=0x800C and dWrLine=0x1234 -> memAddr=0x8000, memWLine=0x1234 stable until memAck, then dWrDone for exactly one cycle.
